// File: rtl/mips32_mem_arbiter.sv
// Single-port memory arbiter sharing unified memory between instruction fetch (IF)
// and data load/store (D); D has priority, a starvation counter guarantees IF progress.
module mips32_mem_arbiter #(
    parameter int unsigned AW         = 10,
    parameter int unsigned DW         = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic          clk1_i,
    input  logic          rst_n_i,
    input  logic          halted_i,

    input  logic          if_req_i,
    input  logic [AW-1:0] if_addr_i,
    output logic          if_gnt_o,
    output logic          if_rvalid_o,
    output logic [DW-1:0] if_rdata_o,

    input  logic          d_req_i,
    input  logic          d_we_i,
    input  logic [AW-1:0] d_addr_i,
    input  logic [DW-1:0] d_wdata_i,
    output logic          d_gnt_o,
    output logic          d_rvalid_o,
    output logic [DW-1:0] d_rdata_o,

    output logic          mem_en_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic [DW-1:0] mem_rdata_i
);

    localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

    typedef enum logic [1:0] {
        OwnNone = 2'd0,
        OwnIf   = 2'd1,
        OwnD    = 2'd2
    } own_e;

    logic [3:0] starve_cnt_q, starve_cnt_d;
    own_e       rd_own_q, rd_own_d;

    logic if_elig;
    logic d_elig;
    logic force_if;
    logic if_win;
    logic d_win;

    // Winner selection: a saturated starvation counter overrides D priority.
    always_comb begin
        if_elig  = if_req_i && !halted_i;
        d_elig   = d_req_i;
        force_if = (starve_cnt_q == StarveMax);
        if_win   = 1'b0;
        d_win    = 1'b0;
        if (force_if && if_elig) begin
            if_win = 1'b1;
        end else if (d_elig) begin
            d_win = 1'b1;
        end else if (if_elig) begin
            if_win = 1'b1;
        end
    end

    always_comb begin
        if_gnt_o    = if_win;
        d_gnt_o     = d_win;
        mem_en_o    = if_win | d_win;
        mem_we_o    = d_win & d_we_i;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (if_win) begin
            mem_addr_o = if_addr_i;
        end else if (d_win) begin
            mem_addr_o  = d_addr_i;
            mem_wdata_o = d_wdata_i;
        end
    end

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (if_win || !if_req_i || halted_i) begin
            starve_cnt_d = 4'd0;
        end else if (if_elig && (starve_cnt_q != StarveMax)) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end

    always_comb begin
        rd_own_d = OwnNone;
        if (if_win) begin
            rd_own_d = OwnIf;
        end else if (d_win && !d_we_i) begin
            rd_own_d = OwnD;
        end
    end

    always_ff @(posedge clk1_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            starve_cnt_q <= 4'd0;
            rd_own_q     <= OwnNone;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            rd_own_q     <= rd_own_d;
        end
    end

    // Read data is gated so the idle requester always sees zero.
    always_comb begin
        if_rvalid_o = (rd_own_q == OwnIf);
        d_rvalid_o  = (rd_own_q == OwnD);
        if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
        d_rdata_o   = d_rvalid_o ? mem_rdata_i : '0;
    end

endmodule

// File: doc/mips32_mem_arbiter.md
# mips32_mem_arbiter

Single-port memory arbiter for the pipe_MIPS32 core. It shares one unified instruction/data memory between the instruction-fetch requester (IF) and the data load/store requester (D). The data side has priority, and a starvation counter guarantees fetch progress. It owns the memory-side control signals and routes 1-cycle-latency read data back to the requester that issued the read.

## Interface
- AW, 10, word-address width
- DW, 32, data width
- STARVE_MAX, 4, number of consecutive denied IF-request cycles after which IF is forced to win; legal range 1..15
- clk1  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- halted  in  1  core halted; blocks IF grants
- if_req  in  1  fetch request, held until if_gnt
- if_addr  in  AW  fetch word address
- if_gnt  out  1  fetch granted this cycle (combinational)
- if_rvalid  out  1  fetch data valid (registered)
- if_rdata  out  DW  fetch data
- d_req  in  1  data request, held until d_gnt
- d_we  in  1  1 = write, 0 = read
- d_addr  in  AW  data word address
- d_wdata  in  DW  write data
- d_gnt  out  1  data granted this cycle (combinational)
- d_rvalid  out  1  load data valid (registered)
- d_rdata  out  DW  load data
- mem_en  out  1  memory access this cycle
- mem_we  out  1  memory write strobe
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  synchronous read data; valid 1 cycle after mem_en && !mem_we

## Operation
- At most one grant per cycle; if_gnt and d_gnt are never high together.
- Eligibility: IF is eligible when `if_req && !halted`. D is eligible when `d_req`.
- Winner selection:
  - If the starvation flag `force_if` is set and IF is eligible, IF wins.
  - Otherwise, if D is eligible, D wins.
  - Otherwise, if IF is eligible, IF wins.
  - Otherwise there is no grant.
- Memory drive:
  - mem_en = if_gnt | d_gnt.
  - mem_we = d_gnt & d_we.
  - mem_addr and mem_wdata come from the winner.
  - With no grant: mem_addr = 0 and mem_wdata = 0.
- Starvation counter `starve_cnt` (4 bits):
  - Increments each cycle IF is eligible but not granted, saturating at STARVE_MAX.
  - Clears on if_gnt, on !if_req, or on halted.
  - `force_if` = (starve_cnt == STARVE_MAX).
- Read return:
  - Owner register `rd_own` ∈ {NONE, IF, D} is set on the grant edge: IF for if_gnt, D for d_gnt with !d_we, NONE otherwise.
  - if_rvalid = (rd_own == IF) and d_rvalid = (rd_own == D).
  - if_rdata and d_rdata are driven by mem_rdata when the matching valid is high, and are 0 otherwise.
- Writes produce no rvalid.
- A write followed next cycle by a read of the same address returns the new data.
- Requesters may change address or deassert only after their grant.
- Toggling halted mid-operation does not affect an in-flight fetch return.

## Timing
- Grant and mem_* drive are combinational, in the same cycle as the request.
- Read data is valid exactly 1 cycle after the grant.
- Throughput is one access per cycle. Back-to-back grants to the same or different requesters are allowed.
- Worst-case IF wait with D continuously requesting: STARVE_MAX denied cycles, then a grant on cycle STARVE_MAX+1.
- Reset (rst_n low, asynchronous): starve_cnt = 0 and rd_own = NONE.
  - if_rvalid, d_rvalid, if_rdata and d_rdata go to 0 immediately.
  - Combinational outputs follow the inputs with the counter at 0.
- Reset asserted while a read is in flight drops that read; no rvalid follows.
- The first grant is possible in the first cycle after rst_n rises.

## Test plan
- **IF read:** memory word 0 = 32'h2801000A; if_req=1, if_addr=0, d_req=0.
  - if_gnt=1, mem_en=1, mem_addr=0 in the same cycle.
  - Next cycle: if_rvalid=1, if_rdata=32'h2801000A, d_rvalid=0.
- **Simultaneous requests:** if_req with addr 1; d_req read with addr 5 (word 5 = 32'h00222000).
  - Cycle 0: d_gnt=1, if_gnt=0.
  - Cycle 1: d_rvalid=1 with 32'h00222000, if_gnt=1.
  - Cycle 2: if_rvalid=1.
- **Starvation (STARVE_MAX=4):** d_req and if_req held high continuously.
  - d_gnt in cycles 0–3.
  - Cycle 4: if_gnt=1, d_gnt=0.
  - Cycles 5–8: D again; IF granted again at cycle 9.
- **Write then read:** d_we=1, d_addr=7, d_wdata=32'h00832800.
  - mem_we=1 for one cycle; d_rvalid stays 0.
  - Next cycle, a read of addr 7 gives d_rvalid=1 with 32'h00832800 one cycle after its grant.
- **Halt:** halted=1 with if_req=1 for 10 cycles.
  - if_gnt stays 0 and starve_cnt stays 0; a concurrent d_req is granted.
  - After halted drops, if_gnt=1 in the same cycle, provided d_req=0.
- **Reset mid-read:** grant an IF read, then pull rst_n low before the next clock edge.
  - if_rvalid=0 and rd_own=NONE; no if_rvalid after rst_n rises.
  - starve_cnt=0.
